// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-scheduling stage.
//   S_DEPTH           - S-memory entries (256, so 8-bit i/j wrap naturally)
//   KEY_BYTES_DEFAULT - default number of secret-key bytes
//   INIT_CYCLES       - cycles spent writing S[i]=i
//   ITER_CYCLES       - cycles per key-schedule iteration (read/read/write/write)
//   ITER_SKIP_CYCLES  - cycles per iteration when the i==j writes are skipped
// Shared with the testbench so expected latencies come from one place.
package rc4_pkg;

  localparam int unsigned S_DEPTH           = 256;
  localparam int unsigned KEY_BYTES_DEFAULT = 3;
  localparam int unsigned INIT_CYCLES       = 256;
  localparam int unsigned ITER_CYCLES       = 7;
  localparam int unsigned ITER_SKIP_CYCLES  = 5;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StRdI,
    StWaitI,
    StCalcJ,
    StRdJ,
    StWaitJ,
    StWrI,
    StWrJ,
    StDone
  } state_t;

endpackage

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key-scheduling algorithm driving a shared 256x8 S-memory.
// Fills S[i]=i, then runs the RC4 swap loop keyed by secret_key, then pulses
// finished for one cycle to hand the S-memory over to the decrypt stage.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle request, sampled only in idle
//   secret_key  in   8*KEY_BYTES key, byte 0 in the most-significant byte
//   finished    out  one-cycle pulse when S holds the final permutation
//   address_s   out  S-memory address
//   data        out  S-memory write data
//   write_en_s  out  S-memory write strobe
//   read_data   in   S-memory read data (valid at the end of the 2nd address cycle)
//
// Build option: define RC4_KSA_SAME_IDX_SKIP_EN to skip both swap writes when
// j==i (5-cycle iteration, key-dependent latency, identical final S).
module rc4_ksa
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   finished,
  output logic [7:0]             address_s,
  output logic [7:0]             data,
  output logic                   write_en_s,
  input  logic [7:0]             read_data
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  state_t                 r_state;
  byte_t                  r_i;
  byte_t                  r_j;
  byte_t                  r_si;
  byte_t                  r_sj;
  logic [KW-1:0]          r_k;
  logic [8*KEY_BYTES-1:0] r_key;

  byte_t                  w_key_byte;
  int unsigned            w_key_base;

  // Byte 0 sits in the top byte, so key index k maps to bit offset (KEY_BYTES-1-k)*8.
  always_comb begin
    w_key_base = (KEY_BYTES - 1 - 32'(r_k)) * 8;
    w_key_byte = r_key[w_key_base +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_k     <= '0;
      r_key   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_key   <= secret_key;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_state <= StInit;
          end
        end
        StInit: begin
          if (r_i == 8'hFF) begin
            r_i     <= '0;
            r_state <= StRdI;
          end else begin
            r_i <= r_i + 8'd1;
          end
        end
        StRdI:   r_state <= StWaitI;
        StWaitI: begin
          r_si    <= read_data;
          r_state <= StCalcJ;
        end
        StCalcJ: begin
          r_j     <= r_j + r_si + w_key_byte;
          r_k     <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
          r_state <= StRdJ;
        end
        StRdJ:   r_state <= StWaitJ;
        StWaitJ: begin
          r_sj <= read_data;
`ifdef RC4_KSA_SAME_IDX_SKIP_EN
          // Swapping an entry with itself is a no-op, so jump to the loop decision.
          if (r_j == r_i) begin
            if (r_i == 8'hFF) begin
              r_state <= StDone;
            end else begin
              r_i     <= r_i + 8'd1;
              r_state <= StRdI;
            end
          end else begin
            r_state <= StWrI;
          end
`else
          r_state <= StWrI;
`endif
        end
        StWrI:   r_state <= StWrJ;
        StWrJ: begin
          if (r_i == 8'hFF) begin
            r_state <= StDone;
          end else begin
            r_i     <= r_i + 8'd1;
            r_state <= StRdI;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Moore outputs; idle and done drive zeros on the memory port.
  always_comb begin
    address_s  = '0;
    data       = '0;
    write_en_s = 1'b0;
    finished   = 1'b0;
    unique case (r_state)
      StInit: begin
        address_s  = r_i;
        data       = r_i;
        write_en_s = 1'b1;
      end
      StRdI, StWaitI: address_s = r_i;
      StRdJ, StWaitJ: address_s = r_j;
      StWrI: begin
        address_s  = r_i;
        data       = r_sj;
        write_en_s = 1'b1;
      end
      StWrJ: begin
        address_s  = r_j;
        data       = r_si;
        write_en_s = 1'b1;
      end
      StDone:  finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/rc4_ksa.md
Name: rc4_ksa

Overview:
- Upstream stage of the RC4 decrypt stage. It builds the cipher state array S in the shared 256x8 S-memory from a secret key.
- Phase 1 (init) writes S[i]=i.
- Phase 2 (key schedule) runs the standard RC4 swap loop.
- On completion it pulses finished. That pulse drives the decrypt stage's start, and the decrypt stage then takes ownership of the S-memory port.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; the key index wraps modulo KEY_BYTES.
- S_DEPTH, 256, number of S-memory entries; fixed to 2^8 so i and j wrap naturally.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- secret_key  in  8*KEY_BYTES  key; byte 0 is the most-significant byte; captured on start.
- finished  out  1  one-cycle pulse when S holds the final permutation.
- address_s  out  8  S-memory address.
- data  out  8  S-memory write data.
- write_en_s  out  1  S-memory write strobe.
- read_data  in  8  S-memory read data.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; finished=0, write_en_s=0, address_s=0, data=0; i=j=0; key counter=0.
- Memory timing: synchronous. The address is held for 2 cycles and read_data is sampled at the end of the second cycle. A write commits on the edge ending a cycle with write_en_s=1.
- Outputs are Moore functions of the state and registers.
- IDLE: if start=1, latch secret_key, clear i, j and key counter, go to INIT.
- INIT: address_s=i, data=i, write_en_s=1. Increment i. When i=255 has been written, clear i and go to RD_I. Takes 256 cycles.
- Key-schedule iteration, 7 cycles: RD_I → WAIT_I → CALC_J → RD_J → WAIT_J → WR_I → WR_J.
  - RD_I, WAIT_I: address_s=i. Capture si at the end of WAIT_I.
  - CALC_J: j <= j + si + key_byte[k], 8-bit and wrapping. k advances and wraps at KEY_BYTES-1.
  - RD_J, WAIT_J: address_s=j. Capture sj.
  - WR_I: address_s=i, data=sj, write_en_s=1.
  - WR_J: address_s=j, data=si, write_en_s=1. Then if i=255 go to DONE, else i++ and go to RD_I.
- DONE: finished=1 for exactly one cycle, then go to IDLE.
- Latency: finished is high in cycle 2049 counted from the edge that sampled start (256 + 256*7 + 1). It is deterministic and independent of the key.
- i==j: both writes occur and the second write wins. The result is correct because si==sj.
- start outside IDLE is ignored. start held high re-triggers only after returning to IDLE.
- A secret_key change mid-run has no effect, because the key is latched.
- Reset mid-operation: immediate return to IDLE. S contents are undefined and a new start is required.
- write_en_s is never asserted in IDLE, RD_*, WAIT_*, CALC_J or DONE.

Optional Feature:
- Macro: RC4_KSA_SAME_IDX_SKIP_EN.
- Defined: in WAIT_J, if j==i, skip WR_I and WR_J and go directly to the next-iteration decision. Such an iteration takes 5 cycles and the total latency becomes key-dependent. The final S contents are identical.
- Undefined: fixed 7-cycle iterations and fixed 2049-cycle latency.

Decomposition:
- Package rc4_pkg holds:
  - the state enum;
  - S_DEPTH and the default KEY_BYTES constant;
  - byte_t typedef (8-bit);
  - the INIT and iteration cycle-count constants, shared by the bench.
- No sub-module. The FSM, the i/j/k counters and the key-byte mux live in one module. Key-byte select is an indexed part-select on k.

Test Plan:
- Reset: hold reset_n=0 with clk running → finished=0, write_en_s=0, address_s=0, data=0; release, no activity without start.
- Key 24'h000000, start 1 cycle → INIT writes S[n]=n (n=0..255). Iteration 0 writes S[0]=0 twice. finished pulses exactly 2049 cycles after start. RAM matches the software KSA model.
- Key 24'h000249 → iteration 0: j=0. Iteration 1: si=1, key byte 0x02, j=3; writes S[1]=3, S[3]=1. Final RAM equals the model.
- Key 24'hFFFFFF → iteration 0: j=0xFF; writes S[0]=0xFF, S[0xFF]=0x00. The j wrap stays correct for all 256 iterations against the model.
- start re-pulsed at cycles 10 and 1500 during a run → ignored; exactly one finished pulse at cycle 2049.
- reset_n low at cycle 1000 → outputs 0 asynchronously; then start with key 24'h000249 → correct RAM and finished after 2049 cycles. With RC4_KSA_SAME_IDX_SKIP_EN, run the same key and check the latency reduction equals 2x the count of i==j iterations.
